// File: rtl/pds_bus_master.sv
// 68000-style PDS bus master fed by the I/O bus slave port, clocked only by C16M.
// Generates C8M phase and the 6800 E clock internally; reports BERR/timeout through IOERR.
module pds_bus_master #(
    parameter int SETUP_CYC = 2,
    parameter int E_DIV     = 20,
    parameter int E_HIGH    = 8,
    parameter int TO_CYC    = 255,
    parameter int TO_W      = 8
) (
    input  logic C16M,
    input  logic RST,
    input  logic IOREQ,
    input  logic IOWE,
    input  logic IOLDS,
    input  logic IOUDS,
    output logic IOACT,
    output logic IOERR,
    output logic E,
    output logic nAS,
    output logic nLDS,
    output logic nUDS,
    output logic nVMA,
    input  logic nDTACK,
    input  logic nVPA,
    input  logic nBERR,
    output logic nAoutOE,
    output logic nDoutOE,
    output logic ALE0,
    output logic nDinLE
);
    localparam int ES_W = $clog2(E_DIV);
    localparam int SU_W = (SETUP_CYC > 1) ? $clog2(SETUP_CYC) : 1;
    localparam logic [ES_W-1:0] ES_LAST = ES_W'(E_DIV - 1);
    localparam logic [ES_W-1:0] E_RISE  = ES_W'(E_DIV - E_HIGH);
    localparam logic [ES_W-1:0] VMA_ES  = ES_W'(E_DIV - E_HIGH - 3);
    localparam logic [ES_W-1:0] ETK_ES  = ES_W'(E_DIV - 2);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TO_CYC);
    localparam logic [SU_W-1:0] SU_LAST = SU_W'(SETUP_CYC - 1);

    typedef enum logic [2:0] {IDLE, SYNC, ADDR, WAIT, END1, END2} state_t;

    state_t state_q, state_d;
    logic ph_q, ph_d, e_q, e_d;
    logic [ES_W-1:0] es_q, es_d;
    logic [SU_W-1:0] su_cnt_q, su_cnt_d;
    logic [TO_W-1:0] to_cnt_q, to_cnt_d;
    logic ioreq_r_q, dtack_s_q, vpa_s_q, berr_s_q;
    logic we_q, we_d, lds_q, lds_d, uds_q, uds_d;
    logic etack_pend_q, etack_pend_d;
    logic ioact_q, ioact_d, ioerr_q, ioerr_d, ale0_q, ale0_d;
    logic nas_q, nas_d, nlds_q, nlds_d, nuds_q, nuds_d;
    logic nvma_q, nvma_d, ndoutoe_q, ndoutoe_d, ndinle_q, ndinle_d;
    logic accept, term, to_hit, etack;
    logic cur_we, cur_lds, cur_uds, addr_ph, ds_ph;

    assign to_hit = (to_cnt_q == TO_LAST);
    assign etack  = ~nvma_q & (es_q == ETK_ES);

    always_ff @(posedge C16M or posedge RST) begin
        if (RST) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d      = state_q;
        su_cnt_d     = su_cnt_q;
        to_cnt_d     = to_cnt_q;
        etack_pend_d = 1'b0;
        accept       = 1'b0;
        term         = 1'b0;
        case (state_q)
            IDLE: if (ioreq_r_q) begin
                accept   = 1'b1;
                su_cnt_d = '0;
                state_d  = ph_q ? SYNC : ADDR;
            end
            SYNC: state_d = ADDR;
            ADDR: if (su_cnt_q == SU_LAST) begin
                state_d  = WAIT;
                to_cnt_d = '0;
            end else begin
                su_cnt_d = su_cnt_q + 1'b1;
            end
            WAIT: begin
                // ETACK lands on a C8M-low cycle, so hold it until the next PH=1
                etack_pend_d = etack_pend_q | etack;
                if (ph_q && (dtack_s_q || etack || etack_pend_q || berr_s_q || to_hit)) begin
                    term    = 1'b1;
                    state_d = END1;
                end else if (!to_hit) begin
                    to_cnt_d = to_cnt_q + 1'b1;
                end
            end
            END1:    state_d = END2;
            END2:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        ph_d    = ~ph_q;
        es_d    = (es_q == ES_LAST) ? '0 : es_q + 1'b1;
        e_d     = (es_d >= E_RISE);
        cur_we  = (state_q == IDLE) ? IOWE  : we_q;
        cur_lds = (state_q == IDLE) ? IOLDS : lds_q;
        cur_uds = (state_q == IDLE) ? IOUDS : uds_q;
        we_d    = cur_we;
        lds_d   = cur_lds;
        uds_d   = cur_uds;
        addr_ph = (state_d == ADDR) || (state_d == WAIT);
        ds_ph   = cur_we ? (state_d == WAIT) : addr_ph;
        nas_d     = ~addr_ph;
        nlds_d    = ~(ds_ph & cur_lds);
        nuds_d    = ~(ds_ph & cur_uds);
        ndoutoe_d = ~(cur_we & (addr_ph || (state_d == END1)));
        ndinle_d  = (state_d == WAIT);
        ioact_d = ioact_q;
        ioerr_d = ioerr_q;
        ale0_d  = ale0_q;
        if (accept) begin
            ioact_d = 1'b1;
            ioerr_d = 1'b0;
            ale0_d  = 1'b1;
        end else if (term) begin
            ioact_d = 1'b0;
            ioerr_d = berr_s_q | to_hit;
            ale0_d  = 1'b0;
        end
        nvma_d = nvma_q;
        if (state_d != WAIT || es_d == '0)
            nvma_d = 1'b1;
        else if (state_q == WAIT && vpa_s_q && es_d == VMA_ES)
            nvma_d = 1'b0;
    end

    always_ff @(posedge C16M or posedge RST) begin
        if (RST) begin
            ph_q <= 1'b0;  es_q <= '0;  e_q <= 1'b0;
            su_cnt_q <= '0;  to_cnt_q <= '0;  etack_pend_q <= 1'b0;
            ioreq_r_q <= 1'b0;  dtack_s_q <= 1'b0;  vpa_s_q <= 1'b0;  berr_s_q <= 1'b0;
            we_q <= 1'b0;  lds_q <= 1'b0;  uds_q <= 1'b0;
            ioact_q <= 1'b0;  ioerr_q <= 1'b0;  ale0_q <= 1'b0;
            nas_q <= 1'b1;  nlds_q <= 1'b1;  nuds_q <= 1'b1;  nvma_q <= 1'b1;
            ndoutoe_q <= 1'b1;  ndinle_q <= 1'b0;
        end else begin
            ph_q <= ph_d;  es_q <= es_d;  e_q <= e_d;
            su_cnt_q <= su_cnt_d;  to_cnt_q <= to_cnt_d;  etack_pend_q <= etack_pend_d;
            ioreq_r_q <= IOREQ;  dtack_s_q <= ~nDTACK;  vpa_s_q <= ~nVPA;  berr_s_q <= ~nBERR;
            we_q <= we_d;  lds_q <= lds_d;  uds_q <= uds_d;
            ioact_q <= ioact_d;  ioerr_q <= ioerr_d;  ale0_q <= ale0_d;
            nas_q <= nas_d;  nlds_q <= nlds_d;  nuds_q <= nuds_d;  nvma_q <= nvma_d;
            ndoutoe_q <= ndoutoe_d;  ndinle_q <= ndinle_d;
        end
    end

    assign IOACT   = ioact_q;
    assign IOERR   = ioerr_q;
    assign E       = e_q;
    assign nAS     = nas_q;
    assign nLDS    = nlds_q;
    assign nUDS    = nuds_q;
    assign nVMA    = nvma_q;
    assign nAoutOE = 1'b0;
    assign nDoutOE = ndoutoe_q;
    assign ALE0    = ale0_q;
    assign nDinLE  = ndinle_q;
endmodule
